// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined segmented ripple-carry adder/subtractor with valid/ready streaming
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic adv;
    logic ovf_q;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
        logic             c_i, v_i;
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] s_q;
        logic             c_q, v_q;

        if (k == 0) begin : g_head
            assign a_i = a;
            assign b_i = b ^ {WIDTH{sub}};
            assign s_i = '0;
            assign c_i = cin ^ sub;
            assign v_i = in_valid;
        end else begin : g_body
            assign a_i = g_stg[k-1].g_fwd.a_q;
            assign b_i = g_stg[k-1].g_fwd.b_q;
            assign s_i = g_stg[k-1].s_q;
            assign c_i = g_stg[k-1].c_q;
            assign v_i = g_stg[k-1].v_q;
        end

        assign seg_sum = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]} + {{SEG{1'b0}}, c_i};

        always_comb begin
            s_n                = s_i;
            s_n[k*SEG +: SEG]  = seg_sum[SEG-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_n;
                c_q <= seg_sum[SEG];
                v_q <= v_i;
            end
        end

        // Operands only need to travel forward while later segments remain.
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q, b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_i;
                    b_q <= b_i;
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered as a^b^sum at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ s_n[WIDTH-1] ^ seg_sum[SEG];
                end
            end
        end
    end

    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign out_valid = g_stg[STAGES-1].v_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder at 32/4, 8/1 and 8/8
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, cin, sub, out_ready;
    logic [31:0] a, b;

    logic        rdy0, ov0, co0, of0;
    logic [31:0] s0;
    logic        rdy1, ov1, co1, of1;
    logic [7:0]  s1;
    logic        rdy2, ov2, co2, of2;
    logic [7:0]  s2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
    );
    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
    );
    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2)
    );

    // Golden model: {ovf, cout, sum} from plain wide arithmetic at width w.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
        logic [32:0] mask, xm, ym, r, lowm, low;
        logic        c0, co, cm;
        mask = (33'd1 << w) - 33'd1;
        xm   = {1'b0, x} & mask;
        ym   = {1'b0, y ^ {32{sb}}} & mask;
        c0   = ci ^ sb;
        r    = xm + ym + {32'd0, c0};
        co   = r[w];
        lowm = mask >> 1;
        low  = (xm & lowm) + (ym & lowm) + {32'd0, c0};
        cm   = low[w-1];
        return {cm ^ co, co, r[31:0] & mask[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Runs at negedge: compare the beat consumed at the coming edge, then log the beat accepted there.
    task automatic sb_step(ref logic [33:0] q[$], input string tag, input int w, input logic rdy,
                           input logic ov, input logic [31:0] s, input logic co, input logic of);
        logic [33:0] e;
        if (rst) begin
            q.delete();
            return;
        end
        if (ov && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL %s extra beat got=%0h exp=none", tag, {of, co, s});
            end else begin
                e = q.pop_front();
                assert ({of, co, s} === e) else begin
                    n_fail++;
                    $error("FAIL %s result got=%0h exp=%0h", tag, {of, co, s}, e);
                end
            end
        end
        if (in_valid && rdy) q.push_back(model(w, a, b, cin, sub));
    endtask

    always @(negedge clk) begin
        sb_step(q0, "w32s4", 32, rdy0, ov0, s0, co0, of0);
        sb_step(q1, "w8s1", 8, rdy1, ov1, {24'd0, s1}, co1, of1);
        sb_step(q2, "w8s8", 8, rdy2, ov2, {24'd0, s2}, co2, of2);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_beat();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int l0, l1, l2;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_sum", 64'(s0), 64'd0);
        chk("rst_cout", 64'(co0), 64'd0);
        chk("rst_ovf", 64'(of0), 64'd0);
        chk("rst_in_ready", 64'(rdy0), 64'd1);

        // Wrap-around add and latency per configuration.
        cyc();
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0;
        cyc();
        in_valid = 1'b0;
        l0 = 0; l1 = 0; l2 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (l0 == 0 && ov0) l0 = i;
            if (l1 == 0 && ov1) l1 = i;
            if (l2 == 0 && ov2) l2 = i;
        end
        chk("latency_w32s4", 64'(l0), 64'd4);
        chk("latency_w8s1", 64'(l1), 64'd1);
        chk("latency_w8s8", 64'(l2), 64'd8);

        // Signed overflow and subtract with borrow.
        cyc();
        in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0;
        cyc();
        a = 32'd5; b = 32'd7; sub = 1'b1;
        cyc();
        in_valid = 1'b0; sub = 1'b0;
        repeat (12) cyc();

        // Back-to-back random stream.
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rnd_beat();
            cyc();
        end
        in_valid = 1'b0;
        repeat (12) cyc();
        chk("stream_drained_w32s4", 64'(q0.size()), 64'd0);

        // Backpressure: fill, stall 6 cycles, release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_beat();
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(rdy0), 64'd0);
            chk("stall_out_valid", 64'(ov0), 64'd1);
            chk("stall_in_flight", 64'(q0.size()), 64'd4);
            chk("stall_hold", 64'({of0, co0, s0}), 64'(q0[0]));
        end
        cyc();
        out_ready = 1'b1;
        repeat (16) cyc();
        chk("stall_drained", 64'(q0.size()), 64'd0);

        // Reset with three beats in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_beat();
            cyc();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("flush_w32s4", 64'(ov0), 64'd0);
        chk("flush_w8s1", 64'(ov1), 64'd0);
        chk("flush_w8s8", 64'(ov2), 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stale", 64'({ov0, ov1, ov2}), 64'd0);
        end
        chk("final_q0", 64'(q0.size()), 64'd0);
        chk("final_q1", 64'(q1.size()), 64'd0);
        chk("final_q2", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
